osd_dii_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one debug-interconnect (DII) output port among several DII flit sources, such as multiple core trace modules of a multi-core tile feeding a single debug ring injection point. A packet, once started, owns the output until its `last` flit is accepted, so packets are never interleaved. The output is registered: one flit buffer, fully pipelined, no bubbles under continuous backpressure-free traffic.

---
 rtl/osd_dii_arbiter_if.sv | 30 +++
 rtl/osd_dii_arbiter.sv | 107 ++++++++++
 tb/tb_osd_dii_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/osd_dii_arbiter_if.sv
// DII flit bus between N requesters, the arbiter and one downstream port.
// The slave modport is the arbiter side; master is the requester/sink side.
interface osd_dii_arbiter_if #(
  parameter int unsigned PORTS = 2
);
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  dii_flit [PORTS-1:0] debug_in;
  logic    [PORTS-1:0] debug_in_ready;
  dii_flit             debug_out;
  logic                debug_out_ready;

  modport master (
    output debug_in,
    input  debug_in_ready,
    input  debug_out,
    output debug_out_ready
  );

  modport slave (
    input  debug_in,
    output debug_in_ready,
    output debug_out,
    input  debug_out_ready
  );
endinterface

// File: rtl/osd_dii_arbiter.sv
// Packet-level round-robin arbiter: N DII flit sources share one registered
// output. A packet holds the output until its last flit transfers.
module osd_dii_arbiter #(
  parameter int unsigned PORTS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  osd_dii_arbiter_if.slave      bus
);

  localparam int unsigned   IW       = $clog2(PORTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(PORTS - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } mode_t;

  mode_t          mode;
  logic [IW-1:0]  grant;
  logic [IW-1:0]  rr;
  logic           out_valid;
  logic           out_last;
  logic [15:0]    out_data;

  logic [PORTS-1:0] valid_vec;
  logic [PORTS-1:0] ready;
  logic             slot_free;
  logic             found;
  logic [IW-1:0]    cand;
  logic [IW-1:0]    sel;
  logic [IW-1:0]    next_rr;
  logic             xfer;
  int               idx;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < int'(PORTS); i++) begin
      valid_vec[i] = bus.debug_in[i].valid;
    end
  end

  assign slot_free = !out_valid || bus.debug_out_ready;

  // Descending scan so the lowest offset from rr wins.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    idx   = 0;
    for (int k = int'(PORTS) - 1; k >= 0; k--) begin
      idx = int'(rr) + k;
      if (idx >= int'(PORTS)) idx -= int'(PORTS);
      if (valid_vec[IW'(idx)]) begin
        found = 1'b1;
        cand  = IW'(idx);
      end
    end
  end

  assign sel     = (mode == LOCKED) ? grant : cand;
  assign next_rr = (sel == LAST_IDX) ? '0 : sel + IW'(1);

  // Accept is held off entirely while reset is asserted.
  always_comb begin
    ready = '0;
    if (!rst) begin
      if (mode == LOCKED) begin
        ready[grant] = slot_free;
      end else if (found && slot_free) begin
        ready[cand] = 1'b1;
      end
    end
  end

  assign xfer = |(ready & valid_vec);

  assign bus.debug_in_ready  = ready;
  assign bus.debug_out.valid = out_valid;
  assign bus.debug_out.last  = out_last;
  assign bus.debug_out.data  = out_data;

  // Load wins over drain, so back-to-back flits leave no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      mode      <= IDLE;
      grant     <= '0;
      rr        <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_last  <= bus.debug_in[sel].last;
      out_data  <= bus.debug_in[sel].data;
      grant     <= sel;
      if (bus.debug_in[sel].last) begin
        mode <= IDLE;
        rr   <= next_rr;
      end else begin
        mode <= LOCKED;
      end
    end else if (bus.debug_out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_osd_dii_arbiter.sv
// Bench for osd_dii_arbiter: directed vector table, corner-case sequences
// and randomized traffic against a packet-level reference model.
module tb_osd_dii_arbiter;

  logic clk;
  logic rst;

  osd_dii_arbiter_if #(.PORTS(4)) if4 ();
  osd_dii_arbiter_if #(.PORTS(3)) if3 ();

  osd_dii_arbiter #(.PORTS(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
  osd_dii_arbiter #(.PORTS(3)) u3 (.clk(clk), .rst(rst), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Port i carries data d+i.
  task automatic set4(input logic [3:0] v, input logic [3:0] l, input logic [15:0] d, input logic ordy);
    for (int i = 0; i < 4; i++) begin
      if4.debug_in[i].valid = v[i];
      if4.debug_in[i].last  = l[i];
      if4.debug_in[i].data  = d + 16'(i);
    end
    if4.debug_out_ready = ordy;
  endtask

  task automatic set3(input logic [2:0] v, input logic [2:0] l, input logic [15:0] d, input logic ordy);
    for (int i = 0; i < 3; i++) begin
      if3.debug_in[i].valid = v[i];
      if3.debug_in[i].last  = l[i];
      if3.debug_in[i].data  = d + 16'(i);
    end
    if3.debug_out_ready = ordy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set4(4'b0000, 4'b0000, 16'h0, 1'b1);
    set3(3'b000, 3'b000, 16'h0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] out4();
    return 32'({if4.debug_out.valid, if4.debug_out.last, if4.debug_out.data});
  endfunction

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [15:0] d;
    logic        ordy;
    logic [3:0]  er;
    logic        eov;
    logic        eol;
    logic [15:0] eod;
  } vec_t;

  vec_t tbl [0:16];

  // Packet-level reference model state (port 4 instance).
  logic        m_ov, m_ol;
  logic [15:0] m_od;
  bit          m_locked;
  int          m_owner, m_rr;

  function automatic logic [3:0] model_ready(input logic [3:0] v, input logic ordy);
    logic [3:0] r;
    bit free;
    r = '0;
    free = !m_ov || ordy;
    if (m_locked) begin
      r[m_owner] = free;
    end else begin
      for (int k = 0; k < 4; k++) begin
        int p;
        p = (m_rr + k) % 4;
        if (v[p]) begin
          r[p] = free;
          break;
        end
      end
    end
    return r;
  endfunction

  logic [3:0]  rv, rl, er;
  logic [15:0] rd [4];
  logic        rordy;
  int          sent [4];
  logic [3:0]  acc;

  initial begin
    rst = 1'b1;
    set4(4'b1111, 4'b0000, 16'h0, 1'b1);
    set3(3'b111, 3'b000, 16'h0, 1'b1);
    @(negedge clk);
    chk("rst_ready4", 32'(if4.debug_in_ready), 32'h0);
    chk("rst_ready3", 32'(if3.debug_in_ready), 32'h0);
    chk("rst_out4", out4(), 32'h0);
    do_reset();

    // Directed table: inputs for the cycle, comb ready and registered output seen that cycle.
    tbl[0]  = '{4'b0010, 4'b0000, 16'h1110, 1'b1, 4'b0010, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{4'b1010, 4'b0000, 16'h2221, 1'b1, 4'b0010, 1'b1, 1'b0, 16'h1111};
    tbl[2]  = '{4'b1010, 4'b0010, 16'h3332, 1'b1, 4'b0010, 1'b1, 1'b0, 16'h2222};
    tbl[3]  = '{4'b1011, 4'b1011, 16'hBEEC, 1'b1, 4'b1000, 1'b1, 1'b1, 16'h3333};
    for (int i = 4; i <= 8; i++)
      tbl[i] = '{4'b0011, 4'b0011, 16'h5550, 1'b0, 4'b0000, 1'b1, 1'b1, 16'hBEEF};
    tbl[9]  = '{4'b0011, 4'b0011, 16'h6660, 1'b1, 4'b0001, 1'b1, 1'b1, 16'hBEEF};
    tbl[10] = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 1'b1, 16'h6660};
    tbl[11] = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 1'b1, 16'h6660};
    tbl[12] = '{4'b0101, 4'b0000, 16'h7770, 1'b1, 4'b0100, 1'b0, 1'b1, 16'h6660};
    tbl[13] = '{4'b0001, 4'b0000, 16'h0000, 1'b1, 4'b0100, 1'b1, 1'b0, 16'h7772};
    tbl[14] = '{4'b0101, 4'b0100, 16'h8880, 1'b1, 4'b0100, 1'b0, 1'b0, 16'h7772};
    tbl[15] = '{4'b0001, 4'b0001, 16'h9990, 1'b1, 4'b0001, 1'b1, 1'b1, 16'h8882};
    tbl[16] = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 1'b1, 16'h9990};

    for (int i = 0; i <= 16; i++) begin
      set4(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), 32'(if4.debug_in_ready), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_out", i), out4(), 32'({tbl[i].eov, tbl[i].eol, tbl[i].eod}));
      @(posedge clk);
      #1;
    end

    // Fairness: every port streams 2-flit packets, grants rotate 0,1,2,3 back to back.
    do_reset();
    for (int i = 0; i < 4; i++) sent[i] = 0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 4; i++) begin
        if4.debug_in[i].valid = 1'b1;
        if4.debug_in[i].last  = sent[i][0];
        if4.debug_in[i].data  = {4'(i), 12'(sent[i])};
      end
      if4.debug_out_ready = 1'b1;
      @(negedge clk);
      if (c < 8) chk($sformatf("fair%0d_ready", c), 32'(if4.debug_in_ready), 32'(4'b0001 << (c / 2)));
      if (c >= 1 && c <= 8)
        chk($sformatf("fair%0d_out", c), out4(),
            32'({1'b1, 1'((c - 1) % 2), 4'((c - 1) / 2), 12'((c - 1) % 2)}));
      acc = if4.debug_in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) sent[i] += int'(acc[i]);
    end

    // Async reset between edges drops the buffered flit and the lock.
    do_reset();
    set4(4'b1000, 4'b0000, 16'hA5A2, 1'b1);
    @(negedge clk);
    chk("arst_grant3", 32'(if4.debug_in_ready), 32'h8);
    @(posedge clk);
    #1;
    chk("arst_loaded", out4(), 32'({1'b1, 1'b0, 16'hA5A5}));
    set4(4'b1001, 4'b0000, 16'h1000, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(if4.debug_out.valid), 32'h0);
    chk("arst_ready", 32'(if4.debug_in_ready), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_port0_prio", 32'(if4.debug_in_ready), 32'h1);
    @(posedge clk);
    #1;

    // Wrap with three ports: rr=2 grants port 2, then port 0, then rr=1.
    do_reset();
    set3(3'b010, 3'b010, 16'h0100, 1'b1);
    @(negedge clk);
    chk("wrap_p1", 32'(if3.debug_in_ready), 32'h2);
    @(posedge clk);
    #1;
    set3(3'b101, 3'b101, 16'h0200, 1'b1);
    @(negedge clk);
    chk("wrap_p2", 32'(if3.debug_in_ready), 32'h4);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("wrap_p0", 32'(if3.debug_in_ready), 32'h1);
    chk("wrap_out_p2", 32'({if3.debug_out.valid, if3.debug_out.last, if3.debug_out.data}),
        32'({1'b1, 1'b1, 16'h0202}));
    @(posedge clk);
    #1;
    set3(3'b111, 3'b111, 16'h0300, 1'b1);
    @(negedge clk);
    chk("wrap_rr1", 32'(if3.debug_in_ready), 32'h2);
    @(posedge clk);
    #1;

    // Randomized traffic against the reference model.
    do_reset();
    m_ov = 1'b0; m_ol = 1'b0; m_od = '0;
    m_locked = 0; m_owner = 0; m_rr = 0;
    for (int c = 0; c < 600; c++) begin
      rv = 4'($urandom);
      rordy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        rl[i] = ($urandom_range(0, 2) == 0);
        rd[i] = 16'($urandom);
        if4.debug_in[i].valid = rv[i];
        if4.debug_in[i].last  = rl[i];
        if4.debug_in[i].data  = rd[i];
      end
      if4.debug_out_ready = rordy;
      @(negedge clk);
      er = model_ready(rv, rordy);
      chk($sformatf("rnd%0d_ready", c), 32'(if4.debug_in_ready), 32'(er));
      chk($sformatf("rnd%0d_out", c), out4(), 32'({m_ov, m_ol, m_od}));
      acc = er & rv;
      if (acc != 4'b0000) begin
        for (int p = 0; p < 4; p++) begin
          if (acc[p]) begin
            m_ov = 1'b1;
            m_ol = rl[p];
            m_od = rd[p];
            if (rl[p]) begin
              m_locked = 0;
              m_rr = (p + 1) % 4;
            end else begin
              m_locked = 1;
              m_owner = p;
            end
          end
        end
      end else if (rordy) begin
        m_ov = 1'b0;
      end
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
